// File: rtl/layer2_pool_unit_if.sv
// Stream interface between the layer-2 conv PE and the layer-2 pooling stage.
// The PE side (master) drives samples and bias; the pool unit (slave) returns pooled strobes.
interface layer2_pool_unit_if #(
  parameter int DATA_W = 16
);
  logic signed [DATA_W-1:0] datain;
  logic                     data_valid;
  logic signed [DATA_W-1:0] bias;
  logic                     bias_enable;
  logic signed [DATA_W-1:0] dataout;
  logic                     pool_out;
  logic                     pool_finish;

  modport master (
    output datain, data_valid, bias, bias_enable,
    input  dataout, pool_out, pool_finish
  );

  modport slave (
    input  datain, data_valid, bias, bias_enable,
    output dataout, pool_out, pool_finish
  );
endinterface

// File: rtl/layer2_pool_unit.sv
// Layer-2 bias + saturation, optional ReLU (LAYER2_POOL_RELU_EN), 2x2 stride-2 max pooling
// over an IN_W x IN_W raster frame; emits one strobed pooled value per window.
module layer2_pool_unit #(
  parameter int IN_W   = 8,
  parameter int DATA_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  layer2_pool_unit_if.slave  bus
);

  localparam int CNT_W = (IN_W > 2) ? $clog2(IN_W) : 1;
  localparam int LB_N  = IN_W / 2;
  localparam int IDX_W = (LB_N > 1) ? $clog2(LB_N) : 1;

  localparam logic signed [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [0:0] { ACTIVE, DONE } state_e;

  state_e                   state_q;
  logic [CNT_W-1:0]         col_q, row_q;
  logic [CNT_W-1:0]         col_d, row_d;
  logic signed [DATA_W-1:0] bias_q;
  logic signed [DATA_W-1:0] hold_q;
  logic signed [DATA_W-1:0] line_buf_q [LB_N];
  logic signed [DATA_W-1:0] dataout_q;
  logic                     pool_out_q;
  logic                     pool_finish_q;

  logic signed [DATA_W:0]   sum;
  logic signed [DATA_W-1:0] b_sat;
  logic signed [DATA_W-1:0] b_d;
  logic signed [DATA_W-1:0] pair_max;
  logic signed [DATA_W-1:0] win_max;
  logic [IDX_W-1:0]         idx;
  logic                     accept;
  logic                     last_sample;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sum    = {bus.datain[DATA_W-1], bus.datain} + {bias_q[DATA_W-1], bias_q};
    b_sat  = sum[DATA_W-1:0];
    // Sign bits disagree only on overflow; the extra top bit gives the true sign.
    if (sum[DATA_W] != sum[DATA_W-1]) begin
      b_sat = sum[DATA_W] ? S_MIN : S_MAX;
    end
`ifdef LAYER2_POOL_RELU_EN
    b_d = (b_sat < 0) ? '0 : b_sat;
`else
    b_d = b_sat;
`endif
    idx      = IDX_W'(col_q >> 1);
    pair_max = (b_d > hold_q) ? b_d : hold_q;
    win_max  = (line_buf_q[idx] > pair_max) ? line_buf_q[idx] : pair_max;

    accept      = bus.data_valid && (state_q == ACTIVE);
    last_sample = (col_q == CNT_W'(IN_W - 1)) && (row_q == CNT_W'(IN_W - 1));
    col_d       = col_q;
    row_d       = row_q;
    if (accept) begin
      if (col_q == CNT_W'(IN_W - 1)) begin
        col_d = '0;
        row_d = (row_q == CNT_W'(IN_W - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ACTIVE;
      col_q         <= '0;
      row_q         <= '0;
      bias_q        <= '0;
      hold_q        <= '0;
      dataout_q     <= '0;
      pool_out_q    <= 1'b0;
      pool_finish_q <= 1'b0;
      // NOTE: the line buffer is a handful of flops, not a RAM, so it is reset like any
      // other register and a fresh frame never sees stale window maxima.
      for (int i = 0; i < LB_N; i++) begin
        line_buf_q[i] <= '0;
      end
    end else begin
      pool_out_q <= 1'b0;
      if (bus.bias_enable) begin
        bias_q <= bus.bias;
      end
      col_q <= col_d;
      row_q <= row_d;
      if (accept) begin
        if (!col_q[0]) begin
          hold_q <= b_d;
        end else if (!row_q[0]) begin
          line_buf_q[idx] <= pair_max;
        end else begin
          dataout_q  <= win_max;
          pool_out_q <= 1'b1;
        end
        if (last_sample) begin
          state_q       <= DONE;
          pool_finish_q <= 1'b1;
        end
      end
    end
  end

  assign bus.dataout     = dataout_q;
  assign bus.pool_out    = pool_out_q;
  assign bus.pool_finish = pool_finish_q;

endmodule
